// File: rtl/sd_pkg.sv
// Shared SD command-side definitions: frame geometry, state encoding,
// command indices and the single-bit CRC7 step.
package sd_pkg;

  localparam logic [6:0]  SD_CRC7_POLY   = 7'h09;
  localparam int unsigned SD_FRAME_BYTES = 6;
  localparam int unsigned SD_HDR_BITS    = 40;
  localparam int unsigned SD_CMD_W       = 6;
  localparam int unsigned SD_ARG_W       = 32;
  localparam int unsigned SD_CRC_W       = 7;
  localparam int unsigned SD_STATE_W     = 3;

  typedef logic [SD_STATE_W-1:0] sd_state_t;

  localparam sd_state_t IDLE = 3'd0;
  localparam sd_state_t CALC = 3'd1;
  localparam sd_state_t SEND = 3'd2;
  localparam sd_state_t GAP  = 3'd3;
  localparam sd_state_t FIN  = 3'd4;

  localparam logic [SD_CMD_W-1:0] CMD0   = 6'd0;
  localparam logic [SD_CMD_W-1:0] CMD8   = 6'd8;
  localparam logic [SD_CMD_W-1:0] CMD17  = 6'd17;
  localparam logic [SD_CMD_W-1:0] CMD55  = 6'd55;
  localparam logic [SD_CMD_W-1:0] ACMD41 = 6'd41;

  // 40-bit command header as it appears on the wire, MSB first
  typedef struct packed {
    logic [1:0]          pre;
    logic [SD_CMD_W-1:0] cmd_idx;
    logic [SD_ARG_W-1:0] arg;
  } sd_hdr_t;

  function automatic logic [SD_CRC_W-1:0] crc7_step(
    input logic [SD_CRC_W-1:0] crc,
    input logic                bit_in,
    input logic [SD_CRC_W-1:0] poly
  );
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? poly : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_framer_if.sv
// Requester + SPI byte-engine signals of the command framer.
// master = framer side, slave = requester / SPI engine side.
interface sd_cmd_framer_if;
  import sd_pkg::*;

  logic                start;
  logic [SD_CMD_W-1:0] cmd_idx;
  logic [SD_ARG_W-1:0] arg;
  logic                busy;
  logic                done;
  logic [SD_CRC_W-1:0] crc_out;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (
    input  start, cmd_idx, arg, tx_ready,
    output busy, done, crc_out, tx_data, tx_valid
  );

  modport slave (
    output start, cmd_idx, arg, tx_ready,
    input  busy, done, crc_out, tx_data, tx_valid
  );

endinterface

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 LFSR, one message bit per enabled cycle; clr wins over en.
module sd_crc7_serial
  import sd_pkg::*;
#(
  parameter logic [SD_CRC_W-1:0] POLY = SD_CRC7_POLY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                bit_in,
  output logic [SD_CRC_W-1:0] crc
);

  logic [SD_CRC_W-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc7_step(crc_q, bit_in, POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_framer.sv
// SD SPI-mode command framer: serial CRC7 over the 40-bit header, then
// streams the 6-byte frame over a valid/ready byte handshake.
module sd_cmd_framer
  import sd_pkg::*;
#(
  parameter logic [SD_CRC_W-1:0] POLY       = SD_CRC7_POLY,
  parameter int unsigned         GAP_CYCLES = 0
) (
  input logic             clk,
  input logic             rst,
  sd_cmd_framer_if.master bus
);

  localparam int unsigned BIT_CNT_W  = 6;
  localparam int unsigned BYTE_IDX_W = 3;
  localparam int unsigned GAP_CNT_W  = 4;

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(SD_HDR_BITS - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(SD_FRAME_BYTES - 1);
  localparam logic [GAP_CNT_W-1:0]  LAST_GAP  = GAP_CNT_W'(GAP_CYCLES - 1);

  sd_state_t                 state_q, state_d;
  logic [SD_HDR_BITS-1:0]    hdr_q, hdr_d;
  sd_hdr_t                   frame_q, frame_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BYTE_IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [GAP_CNT_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [SD_CRC_W-1:0]       crc_out_q, crc_out_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      tx_valid_q, tx_valid_d;
  logic [7:0]                tx_data_q, tx_data_d;

  logic                      hs_c;
  logic                      crc_clr_c;
  logic                      crc_en_c;
  logic [SD_CRC_W-1:0]       crc_val;

  assign hs_c = tx_valid_q & bus.tx_ready;

  sd_crc7_serial #(.POLY(POLY)) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr_c),
    .en     (crc_en_c),
    .bit_in (hdr_q[SD_HDR_BITS-1]),
    .crc    (crc_val)
  );

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      crc_out_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      crc_out_q  <= crc_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = CALC;
      CALC: if (bit_cnt_q == LAST_BIT) state_d = SEND;
      SEND: begin
        if (hs_c) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = FIN;
          end else if (GAP_CYCLES != 0) begin
            state_d = GAP;
          end
        end
      end
      GAP:  if (gap_cnt_q == LAST_GAP) state_d = SEND;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Header capture, CRC sequencing and byte/gap counters
  always_comb begin
    hdr_d      = hdr_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    crc_out_d  = crc_out_q;
    crc_clr_c  = 1'b0;
    crc_en_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          frame_d    = '{pre: 2'b01, cmd_idx: bus.cmd_idx, arg: bus.arg};
          hdr_d      = frame_d;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          gap_cnt_d  = '0;
          crc_clr_c  = 1'b1;
        end
      end
      CALC: begin
        crc_en_c  = 1'b1;
        hdr_d     = hdr_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        // Fold the final bit here so crc_out is ready on SEND entry
        if (bit_cnt_q == LAST_BIT) begin
          crc_out_d = crc7_step(crc_val, hdr_q[SD_HDR_BITS-1], POLY);
        end
      end
      SEND: begin
        if (hs_c) begin
          gap_cnt_d = '0;
          if (byte_idx_q != LAST_BYTE) byte_idx_d = byte_idx_q + 1'b1;
        end
      end
      GAP:  gap_cnt_d = gap_cnt_q + 1'b1;
      default: ;
    endcase
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
    tx_valid_d = (state_d == SEND);
    tx_data_d  = '0;
    if (state_d == SEND) begin
      case (byte_idx_d)
        3'd0:    tx_data_d = {frame_d.pre, frame_d.cmd_idx};
        3'd1:    tx_data_d = frame_d.arg[31:24];
        3'd2:    tx_data_d = frame_d.arg[23:16];
        3'd3:    tx_data_d = frame_d.arg[15:8];
        3'd4:    tx_data_d = frame_d.arg[7:0];
        default: tx_data_d = {crc_out_d, 1'b1};
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crc_out  = crc_out_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Bench for sd_cmd_framer: two instances (GAP_CYCLES 0 and 2) share the stimulus
// and are checked every cycle against a frame/timeline reference model.
module tb_sd_cmd_framer;
  import sd_pkg::*;

  localparam int NL  = 2;
  localparam int BIG = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cmd_idx;
  logic [31:0] arg;
  logic        tx_ready;

  sd_cmd_framer_if bus0 ();
  sd_cmd_framer_if bus2 ();

  assign bus0.start    = start;
  assign bus0.cmd_idx  = cmd_idx;
  assign bus0.arg      = arg;
  assign bus0.tx_ready = tx_ready;
  assign bus2.start    = start;
  assign bus2.cmd_idx  = cmd_idx;
  assign bus2.arg      = arg;
  assign bus2.tx_ready = tx_ready;

  sd_cmd_framer #(.POLY(7'h09), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sd_cmd_framer #(.POLY(7'h09), .GAP_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic check(input string name, input int l, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d cyc=%0d: got %0h expected %0h", name, l, cyc, act, exp);
    end
  endtask

  // CRC7 as the remainder of header*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_of(input logic [5:0] c, input logic [31:0] a);
    logic [39:0] h;
    h = {2'b01, c, a};
    return {h, crc7_ref(h), 1'b1};
  endfunction

  // Reference model state, one entry per lane
  logic        act      [NL];
  int          acc_c    [NL];
  int          nv_c     [NL];
  int          dn_c     [NL];
  int          crc_from [NL];
  int          sent     [NL];
  logic [47:0] exp_fr   [NL];
  logic [6:0]  exp_crc  [NL];
  logic        zero_chk [NL];
  logic [47:0] rx_b     [NL];
  int          done_cnt [NL];
  int          acc_cnt  [NL];
  logic [47:0] flog     [NL][16];
  int          fcyc     [NL][16];
  int          alog     [NL][16];

  initial begin
    for (int l = 0; l < NL; l++) begin
      act[l] = 1'b0; acc_c[l] = 0; nv_c[l] = BIG; dn_c[l] = BIG;
      crc_from[l] = 0; sent[l] = 0; exp_fr[l] = '0; exp_crc[l] = '0;
      zero_chk[l] = 1'b1; rx_b[l] = '0; done_cnt[l] = 0; acc_cnt[l] = 0;
    end
  end

  always @(negedge clk) begin
    logic       o_busy, o_done, o_valid;
    logic [7:0] o_data;
    logic [6:0] o_crc;
    logic       ev, eb, ed, was_idle;
    int         g;
    for (int l = 0; l < NL; l++) begin
      if (l == 0) begin
        o_busy = bus0.busy; o_done = bus0.done; o_valid = bus0.tx_valid;
        o_data = bus0.tx_data; o_crc = bus0.crc_out; g = 0;
      end else begin
        o_busy = bus2.busy; o_done = bus2.done; o_valid = bus2.tx_valid;
        o_data = bus2.tx_data; o_crc = bus2.crc_out; g = 2;
      end
      ev = act[l] && (sent[l] < 6) && (cyc >= nv_c[l]);
      eb = act[l] && (cyc > acc_c[l]) && (cyc <= dn_c[l]);
      ed = act[l] && (cyc == dn_c[l]);
      check("tx_valid", l, 64'(o_valid), 64'(ev));
      check("busy", l, 64'(o_busy), 64'(eb));
      check("done", l, 64'(o_done), 64'(ed));
      if (ev) check("tx_data", l, 64'(o_data), 64'(8'(exp_fr[l] >> (8 * (5 - sent[l])))));
      if (zero_chk[l]) begin
        check("tx_data_reset", l, 64'(o_data), 64'h0);
        zero_chk[l] = 1'b0;
      end
      if (cyc >= crc_from[l]) check("crc_out", l, 64'(o_crc), 64'(exp_crc[l]));
      if (o_done && done_cnt[l] < 16) begin
        flog[l][done_cnt[l]] = rx_b[l];
        fcyc[l][done_cnt[l]] = cyc - acc_c[l] + 1;
        done_cnt[l]++;
      end
      if (rst) begin
        act[l] = 1'b0; sent[l] = 0; exp_crc[l] = '0;
        crc_from[l] = cyc + 1; zero_chk[l] = 1'b1;
      end else begin
        was_idle = !act[l];
        if (ev && tx_ready) begin
          rx_b[l] = {rx_b[l][39:0], o_data};
          sent[l]++;
          if (sent[l] == 6) dn_c[l] = cyc + 1;
          else              nv_c[l] = cyc + 1 + g;
        end
        if (ed) act[l] = 1'b0;
        if (was_idle && start) begin
          act[l] = 1'b1; acc_c[l] = cyc; nv_c[l] = cyc + 41; dn_c[l] = BIG;
          sent[l] = 0; exp_fr[l] = frame_of(cmd_idx, arg);
          exp_crc[l] = crc7_ref({2'b01, cmd_idx, arg}); crc_from[l] = cyc + 41;
          rx_b[l] = '0;
          if (acc_cnt[l] < 16) alog[l][acc_cnt[l]] = cyc;
          acc_cnt[l]++;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [5:0] c, input logic [31:0] a);
    cmd_idx = c; arg = a; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frames(input int t0, input int t1, input int budget, input bit toggle);
    int k;
    k = 0;
    while ((done_cnt[0] < t0 || done_cnt[1] < t1) && k < budget) begin
      if (toggle) tx_ready = (k % 3 == 0);
      tick();
      k++;
    end
    tx_ready = 1'b1;
    check("frames_done", 0, 64'(done_cnt[0] >= t0 && done_cnt[1] >= t1), 64'h1);
  endtask

  initial begin
    int k, a0, a1, d0, d1;
    rst = 1'b1; start = 1'b0; cmd_idx = '0; arg = '0; tx_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // CMD0, ready tied high
    pulse_start(CMD0, 32'h0);
    check("model_pin_cmd0", 0, 64'(exp_fr[0]), 64'h4000_0000_0095);
    wait_frames(1, 1, 400, 1'b0);
    check("cmd0_bytes", 0, 64'(flog[0][0]), 64'h4000_0000_0095);
    check("cmd0_bytes", 1, 64'(flog[1][0]), 64'h4000_0000_0095);
    check("cmd0_crc", 0, 64'(bus0.crc_out), 64'h4A);
    check("cmd0_frame_cycles", 0, 64'(fcyc[0][0]), 64'd48);
    check("cmd0_frame_cycles", 1, 64'(fcyc[1][0]), 64'd58);
    tick();

    // CMD8
    pulse_start(CMD8, 32'h0000_01AA);
    wait_frames(2, 2, 400, 1'b0);
    check("cmd8_bytes", 0, 64'(flog[0][1]), 64'h4800_0001_AA87);
    check("cmd8_bytes", 1, 64'(flog[1][1]), 64'h4800_0001_AA87);
    check("cmd8_crc", 0, 64'(bus0.crc_out), 64'h43);
    tick();

    // CMD55 with tx_ready high one cycle in three
    pulse_start(CMD55, 32'h0);
    wait_frames(3, 3, 800, 1'b1);
    check("cmd55_bytes", 0, 64'(flog[0][2]), 64'h7700_0000_0065);
    check("cmd55_bytes", 1, 64'(flog[1][2]), 64'h7700_0000_0065);
    check("cmd55_crc", 1, 64'(bus2.crc_out), 64'h32);
    tick();

    // Start pulses during CALC and SEND are ignored
    pulse_start(CMD0, 32'h0);
    repeat (10) tick();
    pulse_start(CMD17, 32'hDEAD_BEEF);
    k = 0;
    while (!bus0.tx_valid && k < 60) begin tick(); k++; end
    check("reached_send", 0, 64'(bus0.tx_valid), 64'h1);
    pulse_start(CMD17, 32'hDEAD_BEEF);
    wait_frames(4, 4, 400, 1'b0);
    repeat (60) tick();
    check("single_done", 0, 64'(done_cnt[0]), 64'd4);
    check("single_done", 1, 64'(done_cnt[1]), 64'd4);
    check("ignored_start_bytes", 0, 64'(flog[0][3]), 64'h4000_0000_0095);

    // Reset while byte 3 is presented
    pulse_start(CMD17, 32'h1234_5678);
    k = 0;
    while (sent[0] < 3 && k < 100) begin tick(); k++; end
    tx_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_tx_valid", 0, 64'(bus0.tx_valid), 64'h0);
    check("rst_busy", 0, 64'(bus0.busy), 64'h0);
    tx_ready = 1'b1;
    repeat (60) tick();
    check("no_done_after_rst", 0, 64'(done_cnt[0]), 64'd4);
    check("no_done_after_rst", 1, 64'(done_cnt[1]), 64'd4);
    pulse_start(CMD8, 32'h0000_01AA);
    wait_frames(5, 5, 400, 1'b0);
    check("post_rst_cmd8", 0, 64'(flog[0][4]), 64'h4800_0001_AA87);
    check("post_rst_cmd8", 1, 64'(flog[1][4]), 64'h4800_0001_AA87);
    tick();

    // start held high across two frames, cmd_idx changed mid-frame
    a0 = acc_cnt[0]; a1 = acc_cnt[1]; d0 = done_cnt[0]; d1 = done_cnt[1];
    cmd_idx = CMD0; arg = 32'h0; start = 1'b1;
    repeat (20) tick();
    cmd_idx = CMD8; arg = 32'h0000_01AA;
    k = 0;
    while ((acc_cnt[0] < a0 + 2 || acc_cnt[1] < a1 + 2) && k < 300) begin tick(); k++; end
    start = 1'b0;
    check("two_accepts", 0, 64'(acc_cnt[0] >= a0 + 2 && acc_cnt[1] >= a1 + 2), 64'h1);
    wait_frames(d0 + 2, d1 + 2, 400, 1'b0);
    check("held_first_cmd0", 0, 64'(flog[0][d0]), 64'h4000_0000_0095);
    check("held_first_cmd0", 1, 64'(flog[1][d1]), 64'h4000_0000_0095);
    check("held_second_cmd8", 0, 64'(flog[0][d0 + 1]), 64'h4800_0001_AA87);
    check("held_second_cmd8", 1, 64'(flog[1][d1 + 1]), 64'h4800_0001_AA87);
    check("back_to_back_start", 0, 64'(alog[0][a0 + 1] - alog[0][a0]), 64'd48);
    check("back_to_back_start", 1, 64'(alog[1][a1 + 1] - alog[1][a1]), 64'd58);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_framer.md
Name: sd_cmd_framer

Overview:
- Sequences SD-card SPI command frames: takes a command index and 32-bit argument, computes CRC7 over the 40-bit header, then streams the 6-byte frame to the SPI byte engine over a valid/ready handshake.
- Sits between the SD init/read controller (requester) and the SPI shifter. It owns the only CRC7 computation path on the command side.

Parameters:
- POLY, 7'h09, CRC7 generator polynomial without the x^7 term (x^7+x^3+1).
- GAP_CYCLES, 0, idle cycles inserted after each byte handshake before tx_valid is raised for the next byte (0..15).

Ports:
- clk  in  1  system clock; all logic on rising edge only.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse/level; sampled only in IDLE.
- cmd_idx  in  6  SD command index (0..63).
- arg  in  32  command argument, MSB first on the wire.
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the last byte handshake.
- crc_out  out  7  CRC7 of the last frame; valid from entry to SEND until the next accepted start.
- tx_data  out  8  byte to SPI engine.
- tx_valid  out  1  byte available.
- tx_ready  in  1  SPI engine accepts; a transfer occurs when tx_valid&tx_ready on a rising edge.

Behaviour:
- Only clk and rst exist; one clock domain. rst is synchronous and active-high.
- Reset values: busy=0, done=0, tx_valid=0, tx_data=8'h00, crc_out=7'h00, state=IDLE.
- Header register H[39:0] = {2'b01, cmd_idx, arg}, captured when start=1 in IDLE.
- States:
  - IDLE: wait for start=1, then capture H, clear the CRC register, clear the bit counter, go to CALC.
  - CALC: 40 cycles, one header bit per cycle, MSB first. Per cycle: fb = crc[6]^H[39]; crc = {crc[5:0],1'b0} ^ (fb ? POLY : 0); H shifts left by 1. Move to SEND after bit count 39. crc_out is loaded on that transition.
  - SEND: 6 bytes in order: byte0 = {2'b01,cmd_idx}, bytes1-4 = arg[31:24]..arg[7:0], byte5 = {crc,1'b1}. Use a byte index 0..5. Bytes come from a frame copy kept separately from the shifted H.
    - tx_valid rises the cycle SEND is entered.
    - tx_data/tx_valid hold stable until the handshake. tx_valid must never drop without a handshake.
    - After each handshake: if GAP_CYCLES>0, go to GAP with tx_valid=0; otherwise present the next byte on the next cycle (back-to-back allowed).
    - After the byte-5 handshake, go to FIN.
  - GAP: count GAP_CYCLES, then return to SEND with the next byte.
  - FIN: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Latency: start accepted at cycle T gives tx_valid=1 at T+41 and done at the cycle after the final handshake. The minimum frame is 48 cycles with tx_ready tied high and GAP_CYCLES=0.
- start while busy is ignored; it is not queued. start held high in IDLE begins a new frame the cycle after FIN.
- Inputs cmd_idx/arg changing after capture have no effect on the current frame.
- tx_ready high with tx_valid low has no effect.
- rst mid-frame returns to IDLE on that edge. tx_valid drops immediately. No partial done. The SPI engine must deassert CS on its own reset.
- cmd_idx width is fixed at 6; the start/transmission bits are hardwired, never taken from inputs.

Decomposition:
- Shared package sd_pkg: SD_CRC7_POLY=7'h09, SD_FRAME_BYTES=6, SD_HDR_BITS=40, state encoding localparams (IDLE, CALC, SEND, GAP, FIN), and command-index constants CMD0, CMD8, CMD17, CMD55, ACMD41.
- One sub-module: sd_crc7_serial.
  - Inputs: clk, rst, clr, en, bit_in. Output: crc[6:0].
  - Single-bit LFSR step as defined in CALC.
  - Reusable later for the data-side response check.

Test Plan:
- CMD0, arg=0, tx_ready=1 -> bytes 40 00 00 00 00 95; crc_out=7'h4A; done 1 cycle after the last handshake, 48 cycles after start.
- CMD8, arg=32'h000001AA -> bytes 48 00 00 01 AA 87; crc_out=7'h43.
- CMD55, arg=0, tx_ready toggled 1-of-3 cycles, GAP_CYCLES=2 -> bytes 77 00 00 00 00 65; tx_data stable while tx_valid&!tx_ready; tx_valid low for exactly 2 cycles after each handshake.
- start pulsed during CALC and during SEND of a CMD0 frame -> ignored; exactly one frame emitted, one done pulse.
- rst asserted while SEND is on byte 3 -> next cycle tx_valid=0, busy=0, done never pulses. A following CMD8 start then produces the full correct 6-byte frame.
- start held high across two frames (CMD0, then cmd_idx changed to CMD8 during the first frame) -> first frame is pure CMD0; second frame starts the cycle after FIN with the CMD8 bytes.
